// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns, digit codes and scan FSM states shared by the display encoder and decoder.
package seg7_pkg;
   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [3:0] CODE_DASH = 4'hF;
   localparam logic [3:0] CODE_BAD  = 4'hE;

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   // Index of the highest set select bit; meaningful only for one-hot selects.
   function automatic logic [1:0] sel_index(input logic [3:0] sel);
      return sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
   endfunction
endpackage

// File: rtl/seg7_to_code.sv
// seg7_to_code: maps an active-high a..g segment pattern back to its 4-bit digit code.
module seg7_to_code
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       bad
);
   always_comb begin
      bad = 1'b0;
      case (pattern)
         SEG_0:    code = 4'd0;
         SEG_1:    code = 4'd1;
         SEG_2:    code = 4'd2;
         SEG_3:    code = 4'd3;
         SEG_4:    code = 4'd4;
         SEG_5:    code = 4'd5;
         SEG_6:    code = 4'd6;
         SEG_7:    code = 4'd7;
         SEG_8:    code = 4'd8;
         SEG_9:    code = 4'd9;
         SEG_DASH: code = CODE_DASH;
         default: begin
            code = CODE_BAD;
            bad  = 1'b1;
         end
      endcase
   end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers four digit codes from a multiplexed 7-segment scan and publishes them per frame.
module seg_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 16000,
   parameter int CNT_W          = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] segments_i,
   input  logic [3:0] displays_i,
   output logic [3:0] sign0_o,
   output logic [3:0] sign1_o,
   output logic [3:0] sign2_o,
   output logic [3:0] sign3_o,
   output logic       frame_valid_o,
   output logic       seg_err_o,
   output logic       sel_err_o,
   output logic       stalled_o
);
   logic [6:0] seg_q, seg_p;
   logic [3:0] sel_q, sel_p;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx, tout;
   logic [3:0] code, mask, mask_nx;
   logic [3:0] shadow [4];
   logic [3:0] sign [4];
   logic [1:0] idx;
   logic bad, changed, cap, cap_ok, cap_multi, complete;

   seg7_to_code u_dec (.pattern(seg_q), .code(code), .bad(bad));

   assign changed   = (sel_q != sel_p) || (seg_q != seg_p);
   assign idx       = sel_index(sel_q);
   assign cap_ok    = cap && $onehot(sel_q);
   assign cap_multi = cap && !$onehot(sel_q);
   assign mask_nx   = mask | sel_q;
   assign complete  = cap_ok && (mask_nx == 4'hF);
   assign stalled_o = tout == CNT_W'(TIMEOUT_CYCLES);
   assign sign0_o   = sign[0];
   assign sign1_o   = sign[1];
   assign sign2_o   = sign[2];
   assign sign3_o   = sign[3];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cap      = 1'b0;
      case (state)
         IDLE: if (sel_q != 4'h0) begin
            state_nx = SETTLE;
            cnt_nx   = CNT_W'(1);
         end
         SETTLE: if (changed) begin
            state_nx = (sel_q == 4'h0) ? IDLE : SETTLE;
            cnt_nx   = CNT_W'(1);
         end else if (cnt == CNT_W'(SETTLE_CYCLES)) begin
            state_nx = HOLD;
            cap      = 1'b1;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
         HOLD: if (changed) begin
            state_nx = (sel_q == 4'h0) ? IDLE : SETTLE;
            cnt_nx   = CNT_W'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q         <= '0;
         seg_p         <= '0;
         sel_q         <= '0;
         sel_p         <= '0;
         state         <= IDLE;
         cnt           <= '0;
         tout          <= '0;
         mask          <= '0;
         frame_valid_o <= 1'b0;
         seg_err_o     <= 1'b0;
         sel_err_o     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= '0;
            sign[i]   <= '0;
         end
      end else begin
         seg_q         <= segments_i;
         sel_q         <= displays_i;
         seg_p         <= seg_q;
         sel_p         <= sel_q;
         state         <= state_nx;
         cnt           <= cnt_nx;
         frame_valid_o <= complete;
         seg_err_o     <= cap_ok && bad;
         sel_err_o     <= cap_multi;
         tout          <= cap_ok ? '0 : stalled_o ? tout : tout + 1'b1;
         if (cap_ok) begin
            shadow[idx] <= code;
            mask        <= complete ? 4'h0 : mask_nx;
         end
         // The digit captured this cycle bypasses shadow so the frame publishes atomically.
         if (complete)
            for (int i = 0; i < 4; i++)
               sign[i] <= (2'(i) == idx) ? code : shadow[i];
      end
   end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan scenarios checked against a per-cycle stability-run model of the decoder.
module tb_seg_scan_decoder;
   localparam int S = 4;
   localparam int T = 16000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] segments = '0;
   logic [3:0] displays = '0;
   logic [3:0] s0, s1, s2, s3;
   logic fv, se, sle, stl;
   logic [3:0] s_arr [4];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fv_n = 0, se_n = 0, sle_n = 0, fv_last = 0, fv_prev = 0;

   logic [6:0] tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .segments_i(segments), .displays_i(displays),
      .sign0_o(s0), .sign1_o(s1), .sign2_o(s2), .sign3_o(s3),
      .frame_valid_o(fv), .seg_err_o(se), .sel_err_o(sle), .stalled_o(stl));

   assign s_arr[0] = s0;
   assign s_arr[1] = s1;
   assign s_arr[2] = s2;
   assign s_arr[3] = s3;

   always #5 clk = ~clk;

   function automatic logic [3:0] dec(input logic [6:0] p);
      for (int i = 0; i < 10; i++)
         if (tbl[i] == p) return 4'(i);
      return (p == 7'b0000001) ? 4'hF : 4'hE;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: a capture fires once, when a nonzero select/segment pair has been sampled S+1 times in a row.
   logic [10:0] last;
   int run, m_tout;
   logic [3:0] m_mask;
   logic [3:0] m_sh [4];
   logic [3:0] e_sign [4];
   logic e_fv, e_se, e_sle;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last = '0; run = S + 2; m_mask = '0; m_tout = 0;
         e_fv = 0; e_se = 0; e_sle = 0;
         for (int i = 0; i < 4; i++) begin m_sh[i] = '0; e_sign[i] = '0; end
      end else begin
         cyc++;
         e_fv = 0; e_se = 0; e_sle = 0;
         if (run == S + 1 && last[10:7] != 4'h0 && $onehot(last[10:7])) begin
            for (int i = 0; i < 4; i++)
               if (last[7+i]) begin m_sh[i] = dec(last[6:0]); m_mask[i] = 1'b1; end
            e_se = dec(last[6:0]) == 4'hE;
            if (m_mask == 4'hF) begin e_sign = m_sh; e_fv = 1; m_mask = '0; end
            m_tout = 0;
         end else begin
            e_sle = run == S + 1 && last[10:7] != 4'h0;
            if (m_tout < T) m_tout++;
         end
         if ({displays, segments} == last) run++;
         else begin last = {displays, segments}; run = 1; end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) chk($sformatf("sign%0d", i), int'(s_arr[i]), int'(e_sign[i]));
      chk("frame_valid", int'(fv), int'(e_fv));
      chk("seg_err", int'(se), int'(e_se));
      chk("sel_err", int'(sle), int'(e_sle));
      chk("stalled", int'(stl), int'(m_tout == T));
      if (fv) begin fv_n++; fv_prev = fv_last; fv_last = cyc; end
      if (se) se_n++;
      if (sle) sle_n++;
   end

   task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
      displays = sel;
      segments = seg;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic digits(input int v0, input int v1, input int v2, input int v3, input int n);
      show(4'b0001, tbl[v0], n);
      show(4'b0010, tbl[v1], n);
      show(4'b0100, tbl[v2], n);
      show(4'b1000, tbl[v3], n);
   endtask

   initial begin
      int f0, e0, l0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_sign0", int'(s0), 0);
      chk("reset_flags", int'({fv, se, sle, stl}), 0);
      rst_n = 1'b1;

      // Loopback at driver timing: 2000 cycles per digit.
      digits(1, 2, 3, 4, 2000);
      digits(1, 2, 3, 4, 2000);
      chk("loop_frames", fv_n, 2);
      chk("loop_period", fv_last - fv_prev, 8000);
      chk("loop_signs", int'({s0, s1, s2, s3}), 'h1234);
      chk("loop_errs", se_n + sle_n, 0);

      // Glitch filter: toggling segments never settle; the held value captures once.
      show(4'b0000, 7'd0, 10);
      f0 = fv_n;
      for (int i = 0; i < 6; i++) show(4'b0001, (i % 2 == 0) ? tbl[0] : tbl[1], 2);
      show(4'b0001, tbl[1], 10);
      show(4'b0010, tbl[5], 10);
      show(4'b0100, tbl[6], 10);
      show(4'b1000, tbl[7], 10);
      chk("glitch_frames", fv_n - f0, 1);
      chk("glitch_signs", int'({s0, s1, s2, s3}), 'h1567);

      // Undecodable pattern on digit 2, dash on digit 3.
      e0 = se_n; f0 = fv_n;
      show(4'b0001, tbl[9], 10);
      show(4'b0010, tbl[8], 10);
      show(4'b0100, 7'b0001000, 10);
      show(4'b1000, 7'b0000001, 10);
      chk("bad_seg_err", se_n - e0, 1);
      chk("bad_signs", int'({s0, s1, s2, s3}), 'h98EF);
      chk("bad_frames", fv_n - f0, 1);

      // Multi-hot select between partial captures leaves the mask alone.
      l0 = sle_n; f0 = fv_n;
      show(4'b0001, tbl[3], 10);
      show(4'b0010, tbl[1], 10);
      show(4'b0100, tbl[4], 10);
      show(4'b0011, tbl[8], 10);
      chk("multi_sel_err", sle_n - l0, 1);
      chk("multi_no_frame", fv_n - f0, 0);
      show(4'b1000, tbl[5], 10);
      chk("multi_frame", fv_n - f0, 1);
      chk("multi_signs", int'({s0, s1, s2, s3}), 'h3145);

      // Stall and recovery.
      show(4'b0000, 7'd0, T + 10);
      chk("stall_set", int'(stl), 1);
      show(4'b0001, tbl[2], 10);
      chk("stall_clear", int'(stl), 0);

      // Reset mid-frame discards the partial frame.
      digits(6, 7, 8, 9, 10);
      f0 = fv_n;
      show(4'b0001, tbl[6], 10);
      show(4'b0010, tbl[7], 10);
      show(4'b0100, tbl[8], 10);
      rst_n = 1'b0;
      show(4'b0100, tbl[8], 3);
      chk("rst_signs", int'({s0, s1, s2, s3}), 0);
      chk("rst_flags", int'({fv, se, sle, stl}), 0);
      rst_n = 1'b1;
      show(4'b1000, tbl[9], 10);
      chk("rst_no_frame", fv_n - f0, 0);
      digits(6, 7, 8, 9, 10);
      chk("rst_frame", fv_n - f0, 1);
      chk("rst_signs_after", int'({s0, s1, s2, s3}), 'h6789);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive end of the multiplexed 4-digit 7-segment interface driven by the RTC display driver.
- Samples the one-hot digit-select and segment lines, waits for each digit to be stable, decodes it back to a 4-bit code and rebuilds the four digit values.
- Publishes all four digits together, once per complete scan frame.
- Used for loopback self-check of the RTC display path and for reading an external 7-segment display.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles select+segments must be unchanged before a digit is captured (1..255).
- TIMEOUT_CYCLES, 16000: cycles without a valid capture before stalled_o asserts (driver frame = 8000 cycles at 2000/digit).
- CNT_W, 16: width of the settle and timeout counters; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- segments_i  in  7  segments a..g, a = bit 6, active-high.
- displays_i  in  4  digit select, one-hot, active-high, bit n = digit n.
- sign0_o..sign3_o  out  4 each  decoded digit n, updated only on frame completion.
- frame_valid_o  out  1  one-cycle pulse; sign*_o updated this cycle.
- seg_err_o  out  1  one-cycle pulse; a captured pattern was not in the decode table.
- sel_err_o  out  1  one-cycle pulse; displays_i was stable multi-hot for SETTLE_CYCLES.
- stalled_o  out  1  level; no valid capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (async, rst_ni=0):
  - sign*_o = 4'h0; frame_valid_o, seg_err_o, sel_err_o, stalled_o = 0.
  - Shadow digits = 0, captured mask = 0, counters = 0, FSM = IDLE.
  - Reset mid-frame discards any partial frame.
- Input registering: both inputs pass through one register stage. All comparisons use the registered values.
- Decode table (active-high patterns):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4.
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000001 (dash)→4'hF.
  - Any other pattern→4'hE with seg_err_o pulse.
- FSM:
  - IDLE: select all-zero. Stay. On a non-zero select, go to SETTLE and load settle count 1.
  - SETTLE: if select or segments differ from the previous cycle, restart the count at 1 (stay in SETTLE, or go to IDLE if select becomes zero).
    - When the count reaches SETTLE_CYCLES and select is one-hot: write the decoded code into shadow[n], set mask[n], go to HOLD.
    - When the count reaches SETTLE_CYCLES and select is multi-hot: pulse sel_err_o, go to HOLD, capture nothing.
  - HOLD: wait for any change of select or segments, then go to SETTLE (count 1), or to IDLE if select becomes zero. Only one capture is made per stable interval.
- Capture latency: the capture register write occurs SETTLE_CYCLES+1 clocks after the inputs settle, including the input register stage.
- Frame completion: on the cycle the mask becomes 4'hF (including the digit written that cycle):
  - Copy the shadow digits to sign*_o atomically.
  - Pulse frame_valid_o the next cycle, aligned with the new sign*_o values.
  - Clear the mask.
- Recapture before frame completion: capturing the same digit again overwrites shadow[n]; the mask is unchanged. Digit order is irrelevant.
- Timeout:
  - The counter increments every cycle and saturates at TIMEOUT_CYCLES. stalled_o = 1 while it is saturated.
  - Any one-hot capture clears the counter and stalled_o on the next cycle.
  - sel_err captures do not clear it.
- Simultaneous events: if seg_err and frame completion occur together, both pulses are asserted. The 4'hE digit is still published.

Decomposition:
- Shared package seg7_pkg:
  - the ten digit segment constants;
  - SEG_DASH = 7'b0000001;
  - CODE_DASH = 4'hF; CODE_BAD = 4'hE;
  - FSM state enum (IDLE, SETTLE, HOLD).
- The display driver's encoder also uses this package, so the encoder and decoder tables cannot diverge.
- One sub-module, seg7_to_code: combinational, pattern in → code + bad flag.

Test Plan:
- Loopback with the display driver: sign0..3 = 1,2,3,4 → frame_valid_o pulses every 8000 cycles; sign*_o = 1,2,3,4; no error pulses.
- Glitch filter with SETTLE_CYCLES=4: displays_i=0001 with segments toggling 1111110/0110000 every 2 cycles, then held at 0110000 → exactly one capture, shadow0 = 1.
- Bad pattern: digit 2 shows 0001000 → seg_err_o pulses once; after the frame completes, sign2_o = 4'hE.
- Multi-hot: displays_i=0011 held for 10 cycles → one sel_err_o pulse; mask unchanged; no frame_valid_o.
- Stall: inputs frozen at 0000 for 16000 cycles → stalled_o = 1. Resume scanning → stalled_o = 0 after the first capture.
- Reset mid-frame: rst_ni low after digits 0–2 are captured → all outputs 0. The next frame_valid_o requires all four digits to be captured again.
